// File: rtl/neuron_feeder_pkg.sv
// ============================================================================
// neuron_feeder_pkg : shared types and constants for the 49-input neuron feeder
// Revision 1.0
// ============================================================================
`default_nettype none

package neuron_feeder_pkg;

    localparam int N_INPUTS_DEF = 49;
    localparam int FP_W         = 32;

    typedef logic [FP_W-1:0] fp32_t;

    typedef enum logic [0:0] {
        FILL = 1'b0,
        SWAP = 1'b1
    } feeder_state_e;

endpackage

`default_nettype wire

// File: rtl/feeder_delay_line.sv
// ============================================================================
// feeder_delay_line : DEPTH-stage 1-bit shift register for valid regeneration
// Revision 1.0
// ============================================================================
`default_nettype none

module feeder_delay_line #(
    parameter int DEPTH = 7
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [DEPTH-1:0] sr_q;

    generate
        if (DEPTH == 1) begin : g_single
            always_ff @(posedge clk) begin
                if (rst) sr_q <= '0;
                else     sr_q <= d_i;
            end
        end else begin : g_chain
            always_ff @(posedge clk) begin
                if (rst) sr_q <= '0;
                else     sr_q <= {sr_q[DEPTH-2:0], d_i};
            end
        end
    endgenerate

    assign q_o = sr_q[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/neuron_feeder49.sv
// ============================================================================
// neuron_feeder49 : stream-to-vector front end and result capture for the
// 49-input FP neuron. Optional framing check: NEURON_FEEDER_CHECK_EN.
// Revision 1.0
// ============================================================================
`default_nettype none

module neuron_feeder49
    import neuron_feeder_pkg::*;
#(
    parameter int N_INPUTS   = N_INPUTS_DEF,
    parameter int NEURON_LAT = 7,
    parameter int MIN_HOLD   = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  fp32_t                            s_data,
    input  logic                             s_valid,
    output logic                             s_ready,
    input  logic                             s_last,
    output logic [N_INPUTS-1:0][FP_W-1:0]    input_out,
    output logic                             vec_valid,
    input  fp32_t                            neuron_out,
    output fp32_t                            res_data,
    output logic                             res_valid,
    output logic                             frame_err
);

    localparam int CNT_W  = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
    localparam int HOLD_W = $clog2(MIN_HOLD + 1);

    feeder_state_e                    state_q, state_d;
    logic [CNT_W-1:0]                 cnt_q;
    logic [HOLD_W-1:0]                hold_q;
    logic [N_INPUTS-1:0][FP_W-1:0]    shadow_q;
    logic [N_INPUTS-1:0][FP_W-1:0]    input_q;
    logic                             vv_q;
    fp32_t                            res_q;
    logic                             rv_q;
    logic                             fe_q;

    logic accept;
    logic last_word;
    logic hold_ok;
    logic frame_bad;
    logic do_swap;
    logic tap;

    assign accept    = s_valid && s_ready;
    assign last_word = (cnt_q == CNT_W'(N_INPUTS - 1));
    assign do_swap   = (state_q == SWAP) && hold_ok;

`ifdef NEURON_FEEDER_CHECK_EN
    assign frame_bad = accept && (s_last != last_word);
`else
    logic unused_s_last;
    assign unused_s_last = s_last;
    assign frame_bad     = 1'b0;
`endif

    generate
        if (MIN_HOLD <= 1) begin : g_hold_none
            assign hold_ok = 1'b1;
        end else begin : g_hold_cmp
            assign hold_ok = (hold_q >= HOLD_W'(MIN_HOLD - 1));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) state_q <= FILL;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL:    if (accept && !frame_bad && last_word) state_d = SWAP;
            SWAP:    if (hold_ok) state_d = FILL;
            default: state_d = FILL;
        endcase
    end

    always_comb begin
        s_ready = (state_q == FILL);
    end

    // A framing error just rewinds the write pointer; stale shadow words are
    // always overwritten before the next swap.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (frame_bad) begin
            cnt_q <= '0;
        end else if (accept) begin
            cnt_q <= last_word ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (accept) shadow_q[cnt_q] <= s_data;
    end

    // Reset to MIN_HOLD so the first vector after reset is not delayed.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q <= HOLD_W'(MIN_HOLD);
        end else if (do_swap) begin
            hold_q <= '0;
        end else if (hold_q < HOLD_W'(MIN_HOLD)) begin
            hold_q <= hold_q + HOLD_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            input_q <= '0;
            vv_q    <= 1'b0;
            fe_q    <= 1'b0;
        end else begin
            if (do_swap) input_q <= shadow_q;
            vv_q <= do_swap;
            fe_q <= frame_bad;
        end
    end

    feeder_delay_line #(
        .DEPTH (NEURON_LAT)
    ) u_delay (
        .clk (clk),
        .rst (rst),
        .d_i (vv_q),
        .q_o (tap)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            res_q <= '0;
            rv_q  <= 1'b0;
        end else begin
            if (tap) res_q <= neuron_out;
            rv_q <= tap;
        end
    end

    assign input_out = input_q;
    assign vec_valid = vv_q;
    assign res_data  = res_q;
    assign res_valid = rv_q;
    assign frame_err = fe_q;

endmodule

`default_nettype wire

// File: tb/tb_neuron_feeder49.sv
// ============================================================================
// tb_neuron_feeder49 : randomized scoreboard bench for neuron_feeder49
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_neuron_feeder49;
    import neuron_feeder_pkg::*;

    localparam int N      = 49;
    localparam int LAT    = 7;
    localparam int HOLD_B = 60;
`ifdef NEURON_FEEDER_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [31:0]          nout;
    logic [31:0]          a_data, b_data;
    logic                 a_valid, a_last, a_ready, a_vv, a_rv, a_fe;
    logic                 b_valid, b_last, b_ready, b_vv, b_rv, b_fe;
    logic [N-1:0][31:0]   a_vec, b_vec;
    logic [31:0]          a_res, b_res;

    neuron_feeder49 #(.N_INPUTS(N), .NEURON_LAT(LAT), .MIN_HOLD(1)) u_dut_a (
        .clk(clk), .rst(rst), .s_data(a_data), .s_valid(a_valid), .s_ready(a_ready),
        .s_last(a_last), .input_out(a_vec), .vec_valid(a_vv), .neuron_out(nout),
        .res_data(a_res), .res_valid(a_rv), .frame_err(a_fe));

    neuron_feeder49 #(.N_INPUTS(N), .NEURON_LAT(LAT), .MIN_HOLD(HOLD_B)) u_dut_b (
        .clk(clk), .rst(rst), .s_data(b_data), .s_valid(b_valid), .s_ready(b_ready),
        .s_last(b_last), .input_out(b_vec), .vec_valid(b_vv), .neuron_out(nout),
        .res_data(b_res), .res_valid(b_rv), .frame_err(b_fe));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] nval(input int j);
        return 32'(j) * 32'h9E37_79B1;
    endfunction

    // Reference model state (indices are negedge sample numbers)
    int          k = 0;
    int          idx = 0;
    int          vv_due = -1, swap_k = -1, fe_due = -1;
    logic [31:0] cur[$];
    logic [31:0] vq[$];
    int          rq_due[$];
    logic [31:0] rq_dat[$];
    int          a_rv_n = 0;
    int          b_vv_t[$];
    int          b_nready = 0, b_rv_n = 0;
    bit          bad, exp_ready, exp_rv;

    initial nout = nval(0);

    always @(negedge clk) begin
        exp_ready = (k != swap_k);
        check_eq("a_ready", a_ready, exp_ready);
        check_eq("a_vec_valid", a_vv, k == vv_due);
        if (k == vv_due) begin
            if (vq.size() >= N) begin
                for (int i = 0; i < N; i++)
                    check_eq($sformatf("a_input_out[%0d]", i), a_vec[i], vq.pop_front());
            end
            rq_due.push_back(k + LAT + 1);
            rq_dat.push_back(nval(k + LAT + 1));
        end
        exp_rv = (rq_due.size() > 0) && (rq_due[0] == k);
        check_eq("a_res_valid", a_rv, exp_rv);
        if (exp_rv) begin
            check_eq("a_res_data", a_res, rq_dat[0]);
            void'(rq_due.pop_front());
            void'(rq_dat.pop_front());
        end
        if (a_rv) a_rv_n++;
        check_eq("a_frame_err", a_fe, k == fe_due);

        if (rst) begin
            cur.delete(); vq.delete(); rq_due.delete(); rq_dat.delete();
            idx = 0; vv_due = -1; swap_k = -1; fe_due = -1;
            b_vv_t.delete(); b_nready = 0; b_rv_n = 0;
        end else begin
            if (a_valid && exp_ready) begin
                bad = CHK && (a_last != (idx == N - 1));
                if (bad) begin
                    cur.delete(); idx = 0; fe_due = k + 1;
                end else begin
                    cur.push_back(a_data);
                    idx++;
                    if (idx == N) begin
                        foreach (cur[i]) vq.push_back(cur[i]);
                        cur.delete(); idx = 0;
                        vv_due = k + 2; swap_k = k + 1;
                    end
                end
            end
            if (b_vv) b_vv_t.push_back(k);
            if (!b_ready) b_nready++;
            if (b_rv) begin
                b_rv_n++;
                check_eq("b_res_data", b_res, nval(k));
            end
            check_eq("b_frame_err", b_fe, 0);
        end
        k++;
        nout = nval(k);
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [31:0] d, input logic last);
        logic acc;
        int   guard;
        a_data = d; a_last = last; a_valid = 1'b1;
        guard = 0;
        forever begin
            @(negedge clk); acc = a_ready;
            @(posedge clk); #1;
            if (acc) break;
            guard++;
            if (guard > 500) begin
                check_eq("a_drive_timeout", acc, 1);
                break;
            end
        end
        a_valid = 1'b0;
    endtask

    task automatic send_b_word(input logic [31:0] d, input logic last);
        logic acc;
        int   guard;
        b_data = d; b_last = last; b_valid = 1'b1;
        guard = 0;
        forever begin
            @(negedge clk); acc = b_ready;
            @(posedge clk); #1;
            if (acc) break;
            guard++;
            if (guard > 500) begin
                check_eq("b_drive_timeout", acc, 1);
                break;
            end
        end
        b_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [31:0] base, input bit rnd, input bit gaps);
        logic [31:0] d;
        logic        l;
        for (int i = 0; i < N; i++) begin
            if (gaps) while ($urandom_range(1, 0) == 1) cycles(1);
            d = rnd ? $urandom : base + 32'(i);
            l = CHK ? (i == N - 1) : 1'($urandom_range(1, 0));
            send_word(d, l);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        @(negedge clk);
        check_eq({tag, "_ready"}, a_ready, 1);
        check_eq({tag, "_vv"}, a_vv, 0);
        check_eq({tag, "_rv"}, a_rv, 0);
        check_eq({tag, "_fe"}, a_fe, 0);
        check_eq({tag, "_res"}, a_res, 0);
        for (int i = 0; i < N; i++) check_eq({tag, "_vec"}, a_vec[i], 0);
        @(posedge clk); #1;
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
    endtask

    int rv0;
    int guard;

    initial begin
        rst = 1'b1;
        a_valid = 0; a_data = 0; a_last = 0;
        b_valid = 0; b_data = 0; b_last = 0;
        cycles(3);
        check_reset_vals("rst0");
        rst = 1'b0;
        cycles(1);

        // Ramp pattern, continuous valid
        send_frame(32'h3F80_0000, 1'b0, 1'b0);
        cycles(3);
        check_eq("ramp_w0", a_vec[0], 32'h3F80_0000);
        check_eq("ramp_w48", a_vec[N-1], 32'h3F80_0030);
        cycles(12);

        // Reset mid-frame
        for (int i = 0; i < 30; i++) send_word(32'h4000_0100 + 32'(i), 1'b0);
        pulse_rst();
        check_reset_vals("rst_mid");
        send_frame(32'h4000_0000, 1'b0, 1'b0);
        cycles(15);

        // Reset with a result in flight
        send_frame(32'h4100_0000, 1'b0, 1'b0);
        guard = 0;
        do begin
            @(negedge clk); guard++;
        end while (!a_vv && guard < 20);
        check_eq("vv_seen", a_vv, 1);
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        pulse_rst();
        check_reset_vals("rst_flight");
        cycles(15);
        send_frame(32'h4200_0000, 1'b0, 1'b0);
        cycles(15);

`ifdef NEURON_FEEDER_CHECK_EN
        for (int i = 0; i <= 10; i++) send_word(32'h4300_0000 + 32'(i), i == 10);
        cycles(3);
        send_frame(32'h4400_0000, 1'b0, 1'b0);
        cycles(15);
`endif

        // Randomized data and gaps
        rv0 = a_rv_n;
        repeat (20) send_frame(32'h0, 1'b1, 1'b1);
        cycles(25);
        check_eq("rand_rv_count", a_rv_n - rv0, 20);
        check_eq("vq_empty", vq.size(), 0);
        check_eq("rq_empty", rq_due.size(), 0);

        // Long hold instance: two back-to-back vectors
        pulse_rst();
        cycles(2);
        for (int i = 0; i < 2 * N; i++)
            send_b_word(32'h5000_0000 + 32'(i), (i % N) == N - 1);
        cycles(30);
        check_eq("b_vv_count", b_vv_t.size(), 2);
        if (b_vv_t.size() == 2)
            check_eq("b_vv_spacing", b_vv_t[1] - b_vv_t[0], HOLD_B);
        check_eq("b_not_ready_cycles", b_nready, 12);
        check_eq("b_rv_count", b_rv_n, 2);
        check_eq("b_vec_w5", b_vec[5], 32'h5000_0000 + 32'(N + 5));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
